if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage that replaces the single-register IF stage. It owns the fetch PC and issues one request per cycle to a synchronous instruction memory with 1-cycle read latency. Returned instructions are buffered, each with its PC and PC+4, in a DEPTH-entry queue. The queue feeds ID through a valid/ready handshake, and any redirect from MEM flushes the queue and kills the in-flight fetch.

Parameters:
XLEN, 32, width of PC and instruction
DEPTH, 4, queue entries; power of two, >=2
RESET_PC, 0, fetch PC after reset; must be 4-byte aligned
CW, $clog2(DEPTH)+1, occupancy count width (derived, not overridden)

Ports:
Clk  in  1  clock; all state updates on rising edge
Clr  in  1  reset, synchronous, active-high
Redirect  in  1  MEM-stage PC source select (taken branch/jump)
Redirect_PC  in  XLEN  branch/jump target; bits [1:0] ignored, treated as 0
IMem_Req  out  1  fetch request this cycle
IMem_Addr  out  XLEN  fetch address (current fetch PC)
IMem_Inst  in  XLEN  instruction; valid the cycle after an accepted IMem_Req
Out_Valid  out  1  head entry valid to ID
Out_Ready  in  1  ID accepts the head entry
Out_PC  out  XLEN  head PC
Out_PC4  out  XLEN  head PC+4
Out_Inst  out  XLEN  head instruction
Count  out  CW  queue occupancy

Behaviour:
- Reset (Clr=1 at an edge) clears everything. fetch_pc=RESET_PC, queue empty, Count=0, in-flight flag=0. Out_Valid=0 and IMem_Req=0 while Clr=1. Any pending memory response is dropped.
- pop = Out_Valid & Out_Ready.
- IMem_Req = !Clr & !Redirect & ((Count + inflight − pop) < DEPTH). IMem_Addr = fetch_pc at all times.
- On an edge with IMem_Req=1: fetch_pc <= fetch_pc+4 (wraps modulo 2^XLEN), inflight <= 1, inflight_pc <= fetch_pc. Otherwise inflight <= 0.
- On an edge with inflight=1, no Redirect and no Clr: push {inflight_pc, inflight_pc+4, IMem_Inst} at the queue tail.
- Push and pop in the same cycle are both allowed; Count is unchanged. The credit rule guarantees no push when full. Pop when empty is impossible because Out_Valid=0.
- Out_Valid = (Count != 0) & !Redirect.
- Out_PC, Out_PC4 and Out_Inst always show the head entry. When Count=0 they read 0, 0 and 0 (NOP).
- Latency: a request issued in cycle N is Out_Valid from cycle N+2. After reset releases, the first request (RESET_PC) issues in the first cycle with Clr=0.
- Throughput: sustains 1 instruction/cycle when Out_Ready is held high, for any DEPTH>=2.
- Redirect=1 in cycle N:
  - IMem_Req=0 and Out_Valid=0 in cycle N.
  - At the edge: queue flushed (Count=0), inflight <= 0, so the response returning in N+1 is discarded. fetch_pc <= {Redirect_PC[XLEN-1:2], 2'b00}.
  - First target request in N+1; target instruction Out_Valid in N+3.
- Redirect on consecutive cycles: the last target wins.
- Redirect and Clr together: Clr wins.
- Out_Ready low: the head is held stable with all fields unchanged. Fetch continues until Count+inflight=DEPTH, then IMem_Req stays 0 until a pop.

Test Plan:
- Reset then Out_Ready=1, memory returns Inst=addr^32'hA5A5_0000 → IMem_Addr 0,4,8,… each cycle. Out_Valid rises 2 cycles after first Req. Out_PC=0,4,8 with Out_PC4=4,8,12 consecutive, no bubbles.
- DEPTH=4, Out_Ready=0 for 10 cycles → exactly 4 requests, Count=4, IMem_Req=0. Head stays PC=0. Release Out_Ready → PCs 0,4,8,12,16 in order with no duplicate or skip.
- Streaming, Redirect=1 with Redirect_PC=32'h0000_0103 in cycle N → Out_Valid=0 in N, queue flushed, stale response dropped. IMem_Addr=32'h100 in N+1; Out_PC=32'h100 valid in N+3.
- Redirect in the same cycle as Out_Ready=1 with Count=2 → no pop recorded. Count=0 next cycle; no pre-redirect PC ever reappears.
- RESET_PC=32'hFFFF_FFF8, stream → Out_PC FFFF_FFF8, FFFF_FFFC, 0000_0000. Out_PC4 for FFFF_FFFC is 0000_0000.
- Clr=1 mid-stream with Count=3 and inflight=1 → next cycle Count=0, Out_Valid=0, outputs 0. After release, fetch restarts at RESET_PC and the old response is never enqueued.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues one request per cycle to a
// 1-cycle-latency instruction memory and buffers returns in a DEPTH-entry queue.
module if_fetch_queue #(
   parameter int unsigned        XLEN     = 32,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [XLEN-1:0]    RESET_PC = '0,
   localparam int unsigned       CW       = $clog2(DEPTH) + 1
) (
   input  logic            i_clk,
   input  logic            i_clr,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic [XLEN-1:0] i_imem_inst,
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output logic [XLEN-1:0] o_out_pc,
   output logic [XLEN-1:0] o_out_pc4,
   output logic [XLEN-1:0] o_out_inst,
   output logic [CW-1:0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] inst;
   } entry_t;

   entry_t          r_q [DEPTH];
   logic [AW-1:0]   r_head;
   logic [AW-1:0]   r_tail;
   logic [CW-1:0]   r_count;
   logic [XLEN-1:0] r_fetch_pc;
   logic            r_inflight;
   logic [XLEN-1:0] r_inflight_pc;

   logic            w_valid;
   logic            w_pop;
   logic            w_push;
   logic            w_req;
   logic [CW-1:0]   w_credit;
   logic            w_nonempty;
   entry_t          w_head;
   logic            w_unused_ok;

   // Low address bits of a redirect target are ignored.
   assign w_unused_ok = &{1'b0, i_redirect_pc[1:0]};

   // Handshake and credit: count + in-flight never exceeds DEPTH, so a push never finds the queue full.
   always_comb begin
      w_nonempty = (r_count != '0);
      w_valid    = w_nonempty & ~i_redirect & ~i_clr;
      w_pop      = w_valid & i_out_ready;
      w_credit   = r_count + CW'(r_inflight) - CW'(w_pop);
      w_req      = ~i_clr & ~i_redirect & (w_credit < CW'(DEPTH));
      w_push     = r_inflight & ~i_redirect & ~i_clr;
   end

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
      end else if (i_redirect) begin
         r_fetch_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
         r_inflight <= 1'b0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
      end else begin
         if (w_req) begin
            r_fetch_pc    <= r_fetch_pc + XLEN'(4);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
         end else begin
            r_inflight <= 1'b0;
         end
         if (w_push) r_tail <= r_tail + AW'(1);
         if (w_pop)  r_head <= r_head + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Queue storage needs no reset; empty-queue outputs are masked below.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_q[r_tail] <= '{pc: r_inflight_pc, pc4: r_inflight_pc + XLEN'(4), inst: i_imem_inst};
      end
   end

   always_comb begin
      w_head = r_q[r_head];
      if (!w_nonempty) w_head = '0;
   end

   assign o_imem_req  = w_req;
   assign o_imem_addr = r_fetch_pc;
   assign o_out_valid = w_valid;
   assign o_out_pc    = w_head.pc;
   assign o_out_pc4   = w_head.pc4;
   assign o_out_inst  = w_head.inst;
   assign o_count     = r_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: streaming, backpressure, redirect, wrap and mid-stream reset.
module tb_if_fetch_queue;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr, redirect, out_ready, imem_req, out_valid;
   logic [31:0] redirect_pc, imem_addr, imem_inst, out_pc, out_pc4, out_inst;
   logic [2:0]  count;

   logic        clr_w, redirect_w, ready_w, imem_req_w, out_valid_w;
   logic [31:0] rpc_w, imem_addr_w, imem_inst_w, out_pc_w, out_pc4_w, out_inst_w;
   logic [2:0]  count_w;

   int errors = 0;
   int checks = 0;

   if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
      .i_clk(clk), .i_clr(clr), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_inst(imem_inst),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_pc(out_pc),
      .o_out_pc4(out_pc4), .o_out_inst(out_inst), .o_count(count)
   );

   if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
      .i_clk(clk), .i_clr(clr_w), .i_redirect(redirect_w), .i_redirect_pc(rpc_w),
      .o_imem_req(imem_req_w), .o_imem_addr(imem_addr_w), .i_imem_inst(imem_inst_w),
      .o_out_valid(out_valid_w), .i_out_ready(ready_w), .o_out_pc(out_pc_w),
      .o_out_pc4(out_pc4_w), .o_out_inst(out_inst_w), .o_count(count_w)
   );

   // Synchronous instruction memories, 1-cycle latency, contents derived from the address.
   always @(posedge clk) if (imem_req)   imem_inst   <= imem_addr ^ KEY;
   always @(posedge clk) if (imem_req_w) imem_inst_w <= imem_addr_w ^ KEY;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic do_reset;
      tick; clr = 1'b1; redirect = 1'b0; out_ready = 1'b0; settle;
   endtask

   task automatic test_reset;
      do_reset;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
   endtask

   task automatic test_stream;
      tick; clr = 1'b0; out_ready = 1'b1; settle;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_c0_valid got=%b exp=0", out_valid); end
      tick; settle;
      checks++; if (imem_addr !== 32'h4 || out_valid !== 1'b0) begin errors++; $display("FAIL stream_c1 addr=%h valid=%b exp addr=4 valid=0", imem_addr, out_valid); end
      for (int k = 2; k < 10; k++) begin
         tick; settle;
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4*(k-2)) || out_pc4 !== 32'(4*(k-1)) ||
             out_inst !== (32'(4*(k-2)) ^ KEY) || imem_addr !== 32'(4*k) || count !== 3'd1) begin
            errors++;
            $display("FAIL stream_c%0d valid=%b pc=%h pc4=%h inst=%h addr=%h cnt=%0d exp pc=%h", k,
                     out_valid, out_pc, out_pc4, out_inst, imem_addr, count, 32'(4*(k-2)));
         end
      end
   endtask

   task automatic test_backpressure;
      int reqs = 0;
      int pops = 0;
      logic [31:0] exp = 32'h0;
      do_reset;
      for (int c = 0; c < 10; c++) begin
         tick; clr = 1'b0; out_ready = 1'b0; settle;
         if (imem_req) reqs++;
      end
      checks++; if (reqs != 4) begin errors++; $display("FAIL bp_req_count got=%0d exp=4", reqs); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_count got=%0d exp=4", count); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_stall got=%b exp=0", imem_req); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL bp_head valid=%b pc=%h exp 1/0", out_valid, out_pc); end
      for (int c = 0; c < 30 && pops < 5; c++) begin
         tick; out_ready = 1'b1; settle;
         if (out_valid) begin
            checks++;
            if (out_pc !== exp || out_inst !== (exp ^ KEY)) begin
               errors++; $display("FAIL bp_pop%0d pc=%h inst=%h exp pc=%h", pops, out_pc, out_inst, exp);
            end
            exp = exp + 32'd4;
            pops++;
         end
      end
      checks++; if (pops != 5) begin errors++; $display("FAIL bp_pop_timeout got=%0d exp=5", pops); end
   endtask

   task automatic test_redirect;
      do_reset;
      for (int c = 0; c < 6; c++) begin
         tick; clr = 1'b0; out_ready = 1'b1; settle;
      end
      tick; redirect = 1'b1; redirect_pc = 32'h0000_0103; settle;
      checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL redir_n valid=%b req=%b exp 0/0", out_valid, imem_req); end
      tick; redirect = 1'b0; settle;
      checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_n1_addr addr=%h req=%b exp 100/1", imem_addr, imem_req); end
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL redir_n1_flush cnt=%0d valid=%b exp 0/0", count, out_valid); end
      tick; settle;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_n2_stale valid=%b pc=%h exp valid=0", out_valid, out_pc); end
      tick; settle;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== (32'h100 ^ KEY)) begin errors++; $display("FAIL redir_n3 valid=%b pc=%h inst=%h exp pc=100", out_valid, out_pc, out_inst); end
      tick; settle;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_pc4 !== 32'h108) begin errors++; $display("FAIL redir_n4 valid=%b pc=%h pc4=%h exp 104/108", out_valid, out_pc, out_pc4); end
   endtask

   task automatic test_redirect_pop;
      int pops = 0;
      logic [31:0] exp = 32'h200;
      do_reset;
      for (int c = 0; c < 3; c++) begin
         tick; clr = 1'b0; out_ready = 1'b0; settle;
      end
      tick; out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; settle;
      checks++; if (count !== 3'd2 || out_valid !== 1'b0) begin errors++; $display("FAIL rpop_n cnt=%0d valid=%b exp 2/0", count, out_valid); end
      tick; redirect = 1'b0; settle;
      checks++; if (count !== 3'd0 || imem_addr !== 32'h200) begin errors++; $display("FAIL rpop_n1 cnt=%0d addr=%h exp 0/200", count, imem_addr); end
      for (int c = 0; c < 12; c++) begin
         tick; settle;
         if (out_valid) begin
            checks++;
            if (out_pc !== exp) begin errors++; $display("FAIL rpop_seq%0d pc=%h exp=%h", pops, out_pc, exp); end
            exp = exp + 32'd4;
            pops++;
         end
      end
      checks++; if (pops != 11) begin errors++; $display("FAIL rpop_pops got=%0d exp=11", pops); end
   endtask

   task automatic test_wrap;
      tick; clr_w = 1'b0; settle;
      checks++; if (imem_addr_w !== 32'hFFFF_FFF8 || imem_req_w !== 1'b1) begin errors++; $display("FAIL wrap_c0 addr=%h req=%b exp FFFFFFF8/1", imem_addr_w, imem_req_w); end
      tick; settle;
      checks++; if (imem_addr_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_c1 addr=%h exp FFFFFFFC", imem_addr_w); end
      tick; settle;
      checks++; if (out_valid_w !== 1'b1 || out_pc_w !== 32'hFFFF_FFF8 || out_pc4_w !== 32'hFFFF_FFFC || imem_addr_w !== 32'h0) begin errors++; $display("FAIL wrap_c2 valid=%b pc=%h pc4=%h addr=%h", out_valid_w, out_pc_w, out_pc4_w, imem_addr_w); end
      tick; settle;
      checks++; if (out_pc_w !== 32'hFFFF_FFFC || out_pc4_w !== 32'h0 || out_inst_w !== (32'hFFFF_FFFC ^ KEY)) begin errors++; $display("FAIL wrap_c3 pc=%h pc4=%h inst=%h exp FFFFFFFC/0", out_pc_w, out_pc4_w, out_inst_w); end
      tick; settle;
      checks++; if (out_pc_w !== 32'h0 || out_pc4_w !== 32'h4 || count_w !== 3'd1) begin errors++; $display("FAIL wrap_c4 pc=%h pc4=%h cnt=%0d exp 0/4/1", out_pc_w, out_pc4_w, count_w); end
   endtask

   task automatic test_clr_mid;
      do_reset;
      for (int c = 0; c < 4; c++) begin
         tick; clr = 1'b0; out_ready = 1'b0; settle;
      end
      tick; clr = 1'b1; settle;
      checks++; if (count !== 3'd3 || imem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL clr_n cnt=%0d req=%b valid=%b exp 3/0/0", count, imem_req, out_valid); end
      tick; clr = 1'b0; settle;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL clr_n1 cnt=%0d valid=%b exp 0/0", count, out_valid); end
      checks++; if (out_pc !== 32'h0 || out_pc4 !== 32'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL clr_n1_out pc=%h pc4=%h inst=%h exp 0", out_pc, out_pc4, out_inst); end
      checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL clr_n1_req addr=%h req=%b exp 0/1", imem_addr, imem_req); end
      tick; settle;
      checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL clr_n2 valid=%b cnt=%0d exp 0/0", out_valid, count); end
      tick; settle;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== KEY || count !== 3'd1) begin errors++; $display("FAIL clr_n3 valid=%b pc=%h inst=%h cnt=%0d exp 1/0/%h/1", out_valid, out_pc, out_inst, count, KEY); end
   endtask

   initial begin
      clr = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0; imem_inst = 32'h0;
      clr_w = 1'b1; redirect_w = 1'b0; rpc_w = 32'h0; ready_w = 1'b1; imem_inst_w = 32'h0;
      tick; tick;
      test_reset;
      test_stream;
      test_backpressure;
      test_redirect;
      test_redirect_pop;
      test_wrap;
      test_clr_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
